// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared sizes, constants and interface structs for the
//               two-wide reorder buffer and its dispatch / free-list /
//               architectural-map neighbours.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    localparam int NUM_ROB   = 8;   // power of two, >= 4
    localparam int NUM_SUPER = 2;   // fixed superscalar width
    localparam int NUM_ARCH  = 32;
    localparam int NUM_PR    = 64;
    localparam int NUM_FL    = NUM_PR - NUM_ARCH;

    localparam int ROB_W  = $clog2(NUM_ROB);
    localparam int CNT_W  = ROB_W + 1;            // count spans 0..NUM_ROB
    localparam int PR_W   = $clog2(NUM_PR);
    localparam int FL_W   = $clog2(NUM_FL);
    localparam int ARCH_W = $clog2(NUM_ARCH);

    localparam logic [ARCH_W-1:0] ZERO_REG = '0;
    localparam logic [PR_W-1:0]   ZERO_PR  = '0;

    typedef struct packed {
        logic                            valid;
        logic                            complete;
        logic                            halt;
        logic [ARCH_W-1:0]               dest_idx;
        logic [PR_W-1:0]                 T_idx;
        logic [PR_W-1:0]                 Told_idx;
        logic [FL_W-1:0]                 FL_idx;
    } ROB_ENTRY_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0][ARCH_W-1:0] dest_idx;
        logic [NUM_SUPER-1:0]             halt;
    } DECODER_ROB_OUT_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0][PR_W-1:0]   T_idx;
    } FL_ROB_OUT_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0][PR_W-1:0]   Told_idx;
    } ROB_FL_OUT_t;

    typedef struct packed {
        logic [NUM_SUPER-1:0][ARCH_W-1:0] dest_idx;
        logic [NUM_SUPER-1:0][PR_W-1:0]   T_idx;
    } ROB_ARCH_OUT_t;

    // Age of an entry relative to a base pointer, modulo the ROB size.
    function automatic logic [ROB_W-1:0] wrap_age(input logic [ROB_W-1:0] idx,
                                                  input logic [ROB_W-1:0] base);
        return idx - base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rob.sv
`default_nettype none
// ============================================================================
// Module      : rob
// Description : Two-wide in-order reorder buffer. Allocates two entries per
//               dispatch, marks completion from the CDB, retires up to two
//               entries per cycle in program order, returns Told registers to
//               the free list and supplies the free-list rollback index on a
//               branch mispredict.
// Ports       : clock/reset          - clock, synchronous active-high reset
//               dispatch_en, decoder_ROB_out, FL_ROB_out, Told_idx_in, FL_idx
//                                    - dispatch pair (slot 0 older)
//               complete_en, complete_ROB_idx - CDB completions
//               rollback_en, rollback_ROB_idx - mispredict squash
//               ROB_valid, ROB_idx   - free-space flag, next dispatch indices
//               retire_en, ROB_FL_out, ROB_Arch_out, halt - retire outputs
//               FL_rollback_idx      - stored FL_idx of the rollback target
// Options     : ROB_DEBUG_EN - exposes head, tail, count and rob_entries
//               as output ports.
// Revision    : 1.0 - initial release
// ============================================================================
module rob
    import rob_pkg::*;
(
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                dispatch_en,
    input  DECODER_ROB_OUT_t                    decoder_ROB_out,
    input  FL_ROB_OUT_t                         FL_ROB_out,
    input  logic [NUM_SUPER-1:0][PR_W-1:0]      Told_idx_in,
    input  logic [NUM_SUPER-1:0][FL_W-1:0]      FL_idx,
    input  logic [NUM_SUPER-1:0]                complete_en,
    input  logic [NUM_SUPER-1:0][ROB_W-1:0]     complete_ROB_idx,
    input  logic                                rollback_en,
    input  logic [ROB_W-1:0]                    rollback_ROB_idx,
    output logic                                ROB_valid,
    output logic [NUM_SUPER-1:0][ROB_W-1:0]     ROB_idx,
    output logic [NUM_SUPER-1:0]                retire_en,
    output ROB_FL_OUT_t                         ROB_FL_out,
    output ROB_ARCH_OUT_t                       ROB_Arch_out,
    output logic [FL_W-1:0]                     FL_rollback_idx,
    output logic                                halt
`ifdef ROB_DEBUG_EN
    ,
    output logic [ROB_W-1:0]                    head,
    output logic [ROB_W-1:0]                    tail,
    output logic [CNT_W-1:0]                    count,
    output ROB_ENTRY_t [NUM_ROB-1:0]            rob_entries
`endif
);

`ifndef ROB_DEBUG_EN
    logic [ROB_W-1:0]               head;
    logic [ROB_W-1:0]               tail;
    logic [CNT_W-1:0]               count;
    ROB_ENTRY_t [NUM_ROB-1:0]       rob_entries;
`endif

    logic [NUM_SUPER-1:0][ROB_W-1:0] head_slot;
    logic [CNT_W-1:0]                num_retired;
    logic [ROB_W-1:0]                rb_age;
    logic [NUM_ROB-1:0]              squash;
    logic                            dispatch_ok;

    // ------------------------------------------------------------------
    // Free space and dispatch indices
    // ------------------------------------------------------------------
    assign ROB_valid   = (count <= CNT_W'(NUM_ROB - NUM_SUPER));
    assign dispatch_ok = dispatch_en & ~rollback_en & ROB_valid;

    always_comb begin
        for (int i = 0; i < NUM_SUPER; i++) begin
            ROB_idx[i]   = tail + ROB_W'(i);
            head_slot[i] = head + ROB_W'(i);
        end
    end

    // ------------------------------------------------------------------
    // Retire selection. The second slot only follows a retiring first slot,
    // and never retires behind a halt.
    // ------------------------------------------------------------------
    always_comb begin
        retire_en    = '0;
        ROB_FL_out   = '0;
        ROB_Arch_out = '0;
        halt         = 1'b0;
        num_retired  = '0;

        retire_en[0] = rob_entries[head_slot[0]].valid & rob_entries[head_slot[0]].complete;
        retire_en[1] = retire_en[0] & ~rob_entries[head_slot[0]].halt
                     & rob_entries[head_slot[1]].valid & rob_entries[head_slot[1]].complete;

        for (int i = 0; i < NUM_SUPER; i++) begin
            ROB_FL_out.Told_idx[i]   = ZERO_PR;
            ROB_Arch_out.dest_idx[i] = ZERO_REG;
            ROB_Arch_out.T_idx[i]    = ZERO_PR;
            if (retire_en[i]) begin
                ROB_FL_out.Told_idx[i]   = rob_entries[head_slot[i]].Told_idx;
                ROB_Arch_out.dest_idx[i] = rob_entries[head_slot[i]].dest_idx;
                ROB_Arch_out.T_idx[i]    = rob_entries[head_slot[i]].T_idx;
                halt                     = halt | rob_entries[head_slot[i]].halt;
            end
            num_retired = num_retired + CNT_W'(retire_en[i]);
        end
    end

    // ------------------------------------------------------------------
    // Rollback: everything strictly younger than the branch is squashed.
    // Ages are taken relative to head so the compare is wrap-safe.
    // ------------------------------------------------------------------
    assign FL_rollback_idx = rob_entries[rollback_ROB_idx].FL_idx;
    assign rb_age          = wrap_age(rollback_ROB_idx, head);

    always_comb begin
        squash = '0;
        for (int j = 0; j < NUM_ROB; j++) begin
            squash[j] = (wrap_age(ROB_W'(j), head) > rb_age);
        end
    end

    // ------------------------------------------------------------------
    // State update. Later assignments take priority: completion, then
    // retire clear, then squash / dispatch. Retiring and dispatched slots
    // never overlap because dispatch targets free entries only.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            rob_entries <= '0;
        end else begin
            for (int i = 0; i < NUM_SUPER; i++) begin
                if (complete_en[i] && rob_entries[complete_ROB_idx[i]].valid) begin
                    rob_entries[complete_ROB_idx[i]].complete <= 1'b1;
                end
            end

            for (int i = 0; i < NUM_SUPER; i++) begin
                if (retire_en[i]) begin
                    rob_entries[head_slot[i]] <= '0;
                end
            end

            head <= head + num_retired[ROB_W-1:0];

            if (rollback_en) begin
                for (int j = 0; j < NUM_ROB; j++) begin
                    if (squash[j]) begin
                        rob_entries[j].valid <= 1'b0;
                    end
                end
                tail  <= rollback_ROB_idx + ROB_W'(1);
                count <= CNT_W'(rb_age) + CNT_W'(1) - num_retired;
            end else if (dispatch_ok) begin
                for (int i = 0; i < NUM_SUPER; i++) begin
                    rob_entries[ROB_idx[i]].valid    <= 1'b1;
                    rob_entries[ROB_idx[i]].complete <= 1'b0;
                    rob_entries[ROB_idx[i]].halt     <= decoder_ROB_out.halt[i];
                    rob_entries[ROB_idx[i]].dest_idx <= decoder_ROB_out.dest_idx[i];
                    rob_entries[ROB_idx[i]].T_idx    <= FL_ROB_out.T_idx[i];
                    rob_entries[ROB_idx[i]].Told_idx <= Told_idx_in[i];
                    rob_entries[ROB_idx[i]].FL_idx   <= FL_idx[i];
                end
                tail  <= tail + ROB_W'(NUM_SUPER);
                count <= count + CNT_W'(NUM_SUPER) - num_retired;
            end else begin
                count <= count - num_retired;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rob.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob
// Description : Self-checking bench for rob. Dispatched instructions are
//               pushed to an in-order expectation queue and popped as the
//               ROB retires them; directed checks cover pointers, rollback,
//               wrap-around and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob;
    import rob_pkg::*;

    logic                                clock = 1'b0;
    logic                                reset;
    logic                                dispatch_en;
    DECODER_ROB_OUT_t                    dec;
    FL_ROB_OUT_t                         flo;
    logic [NUM_SUPER-1:0][PR_W-1:0]      told_in;
    logic [NUM_SUPER-1:0][FL_W-1:0]      fl_idx;
    logic [NUM_SUPER-1:0]                complete_en;
    logic [NUM_SUPER-1:0][ROB_W-1:0]     complete_idx;
    logic                                rollback_en;
    logic [ROB_W-1:0]                    rollback_idx;
    logic                                rob_valid;
    logic [NUM_SUPER-1:0][ROB_W-1:0]     rob_idx;
    logic [NUM_SUPER-1:0]                retire_en;
    ROB_FL_OUT_t                         rob_fl;
    ROB_ARCH_OUT_t                       rob_arch;
    logic [FL_W-1:0]                     fl_rb_idx;
    logic                                halt;
`ifdef ROB_DEBUG_EN
    logic [ROB_W-1:0]                    dbg_head;
    logic [ROB_W-1:0]                    dbg_tail;
    logic [CNT_W-1:0]                    dbg_count;
    ROB_ENTRY_t [NUM_ROB-1:0]            dbg_entries;
`endif

    always #5 clock = ~clock;

    rob dut (
        .clock            (clock),
        .reset            (reset),
        .dispatch_en      (dispatch_en),
        .decoder_ROB_out  (dec),
        .FL_ROB_out       (flo),
        .Told_idx_in      (told_in),
        .FL_idx           (fl_idx),
        .complete_en      (complete_en),
        .complete_ROB_idx (complete_idx),
        .rollback_en      (rollback_en),
        .rollback_ROB_idx (rollback_idx),
        .ROB_valid        (rob_valid),
        .ROB_idx          (rob_idx),
        .retire_en        (retire_en),
        .ROB_FL_out       (rob_fl),
        .ROB_Arch_out     (rob_arch),
        .FL_rollback_idx  (fl_rb_idx),
        .halt             (halt)
`ifdef ROB_DEBUG_EN
        ,
        .head             (dbg_head),
        .tail             (dbg_tail),
        .count            (dbg_count),
        .rob_entries      (dbg_entries)
`endif
    );

    typedef struct {
        logic [PR_W-1:0]   told;
        logic [PR_W-1:0]   t;
        logic [ARCH_W-1:0] dest;
        logic              hlt;
        logic [ROB_W-1:0]  idx;
    } exp_t;

    exp_t             sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [ROB_W-1:0] tb_tail = '0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare whatever is retiring now against the head of the queue.
    task automatic sb_check();
        logic exp_halt;
        exp_t e;
        exp_halt = 1'b0;
        check_val("retire_legal", {63'd0, retire_en == 2'b10}, 64'd0);
        for (int i = 0; i < NUM_SUPER; i++) begin
            if (retire_en[i]) begin
                if (sb.size() == 0) begin
                    check_val("sb_unexpected_retire", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("retire_told", rob_fl.Told_idx[i], e.told);
                    check_val("retire_T", rob_arch.T_idx[i], e.t);
                    check_val("retire_dest", rob_arch.dest_idx[i], e.dest);
                    exp_halt = exp_halt | e.hlt;
                end
            end else begin
                check_val("idle_told", rob_fl.Told_idx[i], ZERO_PR);
            end
        end
        check_val("halt_out", halt, exp_halt);
    endtask

    task automatic tick();
        @(negedge clock);
        sb_check();
        @(posedge clock);
        #1;
    endtask

    task automatic set_slots(input logic [ARCH_W-1:0] d0, input logic [ARCH_W-1:0] d1,
                             input logic [PR_W-1:0] t0, input logic [PR_W-1:0] t1,
                             input logic [PR_W-1:0] o0, input logic [PR_W-1:0] o1,
                             input logic h0, input logic [FL_W-1:0] f0, input logic [FL_W-1:0] f1);
        dec.dest_idx[0] = d0;  dec.dest_idx[1] = d1;
        dec.halt        = {1'b0, h0};
        flo.T_idx[0]    = t0;  flo.T_idx[1]    = t1;
        told_in[0]      = o0;  told_in[1]      = o1;
        fl_idx[0]       = f0;  fl_idx[1]       = f1;
    endtask

    task automatic dispatch(input logic [ARCH_W-1:0] d0, input logic [ARCH_W-1:0] d1,
                            input logic [PR_W-1:0] t0, input logic [PR_W-1:0] t1,
                            input logic [PR_W-1:0] o0, input logic [PR_W-1:0] o1,
                            input logic h0, input logic [FL_W-1:0] f0, input logic [FL_W-1:0] f1,
                            input logic accepted);
        logic [ROB_W-1:0] nxt;
        nxt = tb_tail + ROB_W'(1);
        check_val("rob_idx", rob_idx, {nxt, tb_tail});
        set_slots(d0, d1, t0, t1, o0, o1, h0, f0, f1);
        dispatch_en = 1'b1;
        if (accepted) begin
            sb.push_back('{told: o0, t: t0, dest: d0, hlt: h0,   idx: tb_tail});
            sb.push_back('{told: o1, t: t1, dest: d1, hlt: 1'b0, idx: nxt});
            tb_tail = tb_tail + ROB_W'(2);
        end
        tick();
        dispatch_en = 1'b0;
    endtask

    task automatic complete(input logic [1:0] en, input logic [ROB_W-1:0] i0, input logic [ROB_W-1:0] i1);
        complete_en     = en;
        complete_idx[0] = i0;
        complete_idx[1] = i1;
        tick();
        complete_en     = '0;
    endtask

    initial begin
        reset = 1'b1; dispatch_en = 1'b0; complete_en = '0; complete_idx = '0;
        rollback_en = 1'b0; rollback_idx = '0;
        set_slots('0, '0, '0, '0, '0, '0, 1'b0, '0, '0);
        @(posedge clock); #1;
        tick();
        reset = 1'b0;

        // Reset state
        check_val("rst_retire_en", retire_en, 2'b00);
        check_val("rst_rob_valid", rob_valid, 1'b1);
        check_val("rst_rob_idx", rob_idx, {3'd1, 3'd0});
        check_val("rst_told", rob_fl.Told_idx, '0);
        check_val("rst_halt", halt, 1'b0);
        check_val("rst_fl_rb", fl_rb_idx, '0);
        check_val("rst_count", dut.count, '0);

        // Fill: entry 5 carries no destination (ZERO_REG / ZERO_PR)
        dispatch(5'd1, 5'd2, 6'd33, 6'd34, 6'd1, 6'd2, 1'b0, 5'd1, 5'd2, 1'b1);
        dispatch(5'd3, 5'd4, 6'd35, 6'd36, 6'd3, 6'd4, 1'b0, 5'd3, 5'd4, 1'b1);
        dispatch(5'd5, 5'd0, 6'd37, 6'd0,  6'd5, 6'd0, 1'b0, 5'd5, 5'd6, 1'b1);
        dispatch(5'd7, 5'd8, 6'd39, 6'd40, 6'd7, 6'd8, 1'b0, 5'd7, 5'd8, 1'b1);
        check_val("full_rob_valid", rob_valid, 1'b0);
        check_val("full_count", dut.count, 4'd8);

        // Dispatch while full is dropped
        dispatch(5'd9, 5'd9, 6'd50, 6'd51, 6'd9, 6'd9, 1'b0, 5'd9, 5'd9, 1'b0);
        check_val("full_drop_count", dut.count, 4'd8);
        check_val("full_drop_idx", rob_idx, {3'd1, 3'd0});

        // Out-of-order completion
        complete(2'b10, 3'd0, 3'd1);
        check_val("ooo_wait", retire_en, 2'b00);
        complete(2'b01, 3'd0, 3'd0);
        check_val("ooo_retire", retire_en, 2'b11);
        check_val("ooo_told", rob_fl.Told_idx, {6'd2, 6'd1});
        tick();
        check_val("ooo_head", dut.head, 3'd2);
        check_val("ooo_count", dut.count, 4'd6);

        // Single-slot retire
        complete(2'b01, 3'd2, 3'd0);
        check_val("single_retire", retire_en, 2'b01);
        check_val("single_told1", rob_fl.Told_idx[1], ZERO_PR);
        tick();
        check_val("single_head", dut.head, 3'd3);
        check_val("single_count", dut.count, 4'd5);

        // Advance head to 6 (entry 5 has no destination)
        complete(2'b11, 3'd3, 3'd4);
        check_val("adv_retire2", retire_en, 2'b11);
        tick();
        complete(2'b01, 3'd5, 3'd0);
        check_val("adv_retire1", retire_en, 2'b01);
        tick();
        dispatch(5'd10, 5'd11, 6'd45, 6'd46, 6'd20, 6'd21, 1'b0, 5'd3, 5'd4, 1'b1);
        check_val("wrap_head_pre", dut.head, 3'd6);
        check_val("wrap_tail_pre", rob_idx[0], 3'd2);

        // Wrap-around retire of entries 6 and 7
        complete(2'b11, 3'd6, 3'd7);
        check_val("wrap_retire", retire_en, 2'b11);
        tick();
        check_val("wrap_head", dut.head, 3'd0);
        check_val("wrap_count", dut.count, 4'd2);

        // Rollback with simultaneous dispatch
        dispatch(5'd12, 5'd13, 6'd47, 6'd48, 6'd22, 6'd23, 1'b0, 5'd5, 5'd6, 1'b1);
        dispatch(5'd14, 5'd15, 6'd49, 6'd50, 6'd24, 6'd25, 1'b0, 5'd7, 5'd8, 1'b1);
        check_val("rb_pre_count", dut.count, 4'd6);
        rollback_en  = 1'b1;
        rollback_idx = 3'd2;
        dispatch_en  = 1'b1;
        set_slots(5'd16, 5'd17, 6'd51, 6'd52, 6'd26, 6'd27, 1'b0, 5'd9, 5'd10);
        #1;
        check_val("rb_fl_idx", fl_rb_idx, 5'd5);
        tick();
        rollback_en = 1'b0;
        dispatch_en = 1'b0;
        while (sb.size() > 0 && sb[$].idx != 3'd2) void'(sb.pop_back());
        tb_tail = 3'd3;
        check_val("rb_rob_idx", rob_idx, {3'd4, 3'd3});
        check_val("rb_count", dut.count, 4'd3);
        check_val("rb_valid2", dut.rob_entries[2].valid, 1'b1);
        check_val("rb_valid3", dut.rob_entries[3].valid, 1'b0);
        check_val("rb_valid4", dut.rob_entries[4].valid, 1'b0);
        check_val("rb_valid5", dut.rob_entries[5].valid, 1'b0);

        // Late completion to a squashed entry is ignored
        complete(2'b01, 3'd4, 3'd0);
        check_val("late_cmpl", dut.rob_entries[4].complete, 1'b0);
        check_val("late_retire", retire_en, 2'b00);

        // Drain the surviving entries 0..2
        complete(2'b11, 3'd0, 3'd1);
        check_val("drain_retire2", retire_en, 2'b11);
        tick();
        complete(2'b01, 3'd2, 3'd0);
        check_val("drain_retire1", retire_en, 2'b01);
        tick();
        check_val("drain_count", dut.count, 4'd0);
        check_val("drain_idle", retire_en, 2'b00);

        // Halt in slot 0 blocks the younger slot for one cycle
        dispatch(5'd18, 5'd19, 6'd53, 6'd54, 6'd28, 6'd29, 1'b1, 5'd11, 5'd12, 1'b1);
        complete(2'b11, 3'd3, 3'd4);
        check_val("halt_retire", retire_en, 2'b01);
        check_val("halt_flag", halt, 1'b1);
        tick();
        check_val("post_halt_retire", retire_en, 2'b01);
        check_val("post_halt_flag", halt, 1'b0);
        tick();
        check_val("post_halt_count", dut.count, 4'd0);

        // Reset mid-operation discards everything
        dispatch(5'd20, 5'd21, 6'd55, 6'd56, 6'd30, 6'd31, 1'b0, 5'd13, 5'd14, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        tb_tail = '0;
        check_val("mid_rst_count", dut.count, 4'd0);
        check_val("mid_rst_idx", rob_idx, {3'd1, 3'd0});
        check_val("mid_rst_head", dut.head, 3'd0);
        complete(2'b01, 3'd5, 3'd0);
        check_val("mid_rst_retire", retire_en, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
